// File: rtl/clk_div_sched_if.sv
// Configuration port of the clock-divider controller: valid/ready ratio
// request plus the illegal-ratio error pulse.
interface clk_div_sched_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock divider. Ratio changes are queued and applied only on
// a clk_out period boundary, so clk_out never produces a runt pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_OFF  | divider stopped, clk_out held low, accepts a start ratio
//   ST_RUN  | dividing by cur_div, accepts a new ratio (goes to ST_PEND)
//   ST_PEND | dividing by cur_div, pend_div applied at end of this period
module clk_div_sched #(
  parameter int DIV_W = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  clk_div_sched_if.slave        cfg,
  output logic                  clk_out,
  output logic                  period_tick,
  output logic                  busy
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]       state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] cur_div, cur_nx;
  logic [DIV_W-1:0] pend_div, pend_nx;
  logic             clk_nx;
  logic             err_q;
  logic             accept;
  logic             req_bad;
  logic             req_stop;
  logic             last;

  assign accept   = cfg.cfg_valid && cfg.cfg_ready;
  assign req_bad  = (cfg.cfg_div == DIV_W'(1));
  assign req_stop = (cfg.cfg_div == '0);
  // cur_div is only meaningful outside ST_OFF, so the wrap compare is gated.
  assign last     = (state != ST_OFF) && (cnt == cur_div - 1'b1);

  assign cfg.cfg_ready = (state != ST_PEND);
  assign cfg.cfg_err   = err_q;
  assign period_tick   = last;
  assign busy          = (state != ST_OFF);

  // Next-state, counter and ratio selection; an illegal ratio changes nothing.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cur_nx   = cur_div;
    pend_nx  = pend_div;
    case (state)
      ST_OFF: begin
        cnt_nx = '0;
        if (accept && !req_bad && !req_stop) begin
          state_nx = ST_RUN;
          cur_nx   = cfg.cfg_div;
        end
      end
      ST_RUN: begin
        cnt_nx = last ? '0 : cnt + 1'b1;
        if (accept && !req_bad) begin
          pend_nx  = cfg.cfg_div;
          state_nx = ST_PEND;
        end
      end
      ST_PEND: begin
        if (last) begin
          cnt_nx = '0;
          if (pend_div == '0) begin
            state_nx = ST_OFF;
          end else begin
            cur_nx   = pend_div;
            state_nx = ST_RUN;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_OFF;
        cnt_nx   = '0;
      end
    endcase
    // clk_out is computed from the post-edge count so it moves with cnt.
    clk_nx = (state_nx != ST_OFF) && (cnt_nx < (cur_nx >> 1));
  end

  // Controller state, counter and ratio registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= ST_OFF;
      cnt      <= '0;
      cur_div  <= '0;
      pend_div <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_div  <= cur_nx;
      pend_div <= pend_nx;
    end
  end

  // Output flops: clk_out straight from a register, error pulse for ratio 1.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      clk_out <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      clk_out <= clk_nx;
      err_q   <= accept && req_bad;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched. Each step drives the config port for one
// edge and queues the expected {clk_out, period_tick, busy, cfg_ready,
// cfg_err} for the cycle after that edge; the entry is popped and compared
// once the edge has happened.
module tb_clk_div_sched;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic clk_out, period_tick, busy;

  clk_div_sched_if #(.DIV_W(8)) cfg ();

  clk_div_sched #(.DIV_W(8)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .cfg         (cfg.slave),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  logic [4:0] expq[$];
  int         checks = 0;
  int         errors = 0;
  int         step   = 0;
  string      tag    = "reset";

  task automatic compare();
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {clk_out, period_tick, busy, cfg.cfg_ready, cfg.cfg_err};
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $error("FAIL %s step%0d scoreboard empty, observed %b", tag, step, obs);
    end else begin
      exp = expq.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s step%0d observed %b expected %b (clk tick busy rdy err)",
               tag, step, obs, exp);
      end
    end
    step++;
  endtask

  // Drive one request cycle, then check the outputs after the edge.
  task automatic st(input logic v, input logic [7:0] d, input logic [4:0] exp);
    cfg.cfg_valid = v;
    cfg.cfg_div   = d;
    expq.push_back(exp);
    @(posedge clk_in);
    #1;
    compare();
  endtask

  // Check the current outputs without advancing the clock.
  task automatic now(input logic [4:0] exp);
    expq.push_back(exp);
    compare();
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    #2;
    now(5'b00010);
    #1 reset = 1'b1;

    tag = "start_n4";
    st(1, 4, 5'b10110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);

    tag = "n4_to_n6";
    st(0, 0, 5'b10110);
    st(0, 0, 5'b10110);
    st(1, 6, 5'b00100);
    st(0, 0, 5'b01100);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);

    tag = "n6_to_n5_on_tick";
    st(1, 5, 5'b10100);
    st(0, 0, 5'b10100);
    st(0, 0, 5'b10100);
    st(0, 0, 5'b00100);
    st(0, 0, 5'b00100);
    st(0, 0, 5'b01100);
    st(0, 0, 5'b10110);

    tag = "n5_stop";
    st(1, 0, 5'b10100);
    st(0, 0, 5'b00100);
    st(0, 0, 5'b00100);
    st(0, 0, 5'b01100);
    st(0, 0, 5'b00010);
    st(0, 0, 5'b00010);

    tag = "illegal_off";
    st(1, 1, 5'b00011);
    st(0, 0, 5'b00010);

    tag = "illegal_run_n3";
    st(1, 3, 5'b10110);
    st(0, 0, 5'b00110);
    st(1, 1, 5'b01111);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);

    tag = "n2_req_on_tick";
    st(1, 2, 5'b10100);
    st(0, 0, 5'b00100);
    st(0, 0, 5'b01100);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b01110);
    st(1, 4, 5'b10100);
    st(0, 0, 5'b01100);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);

    tag = "same_ratio";
    st(1, 4, 5'b10100);
    st(0, 0, 5'b10100);
    st(0, 0, 5'b00100);
    st(0, 0, 5'b01100);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b10110);

    tag = "reset_pend_n7";
    st(1, 7, 5'b00100);
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    #2 reset = 1'b0;
    #1;
    now(5'b00010);
    @(posedge clk_in);
    #1;
    now(5'b00010);
    #1 reset = 1'b1;

    tag = "after_reset_n3";
    st(1, 3, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);
    st(0, 0, 5'b10110);
    st(0, 0, 5'b00110);
    st(0, 0, 5'b01110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Programmable clock-divider controller with a valid/ready configuration port.
- Generates a divided clock from clk_in and sequences divide-ratio changes so they take effect only on a period boundary. This keeps clk_out glitch-free and free of runt pulses.
- Sits between configuration logic and the clock-divider datapath; it replaces fixed half-rate dividers wherever the ratio must change at run time.

Parameters:
- DIV_W, 8, width of the divide ratio field; ratios from 2 to 2^DIV_W-1 are legal.

Ports:
- clk_in  input  1  source clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  request to load a new divide ratio.
- cfg_div  input  DIV_W  requested ratio N: 0 means stop; 1 is illegal; 2 or more means divide by N.
- cfg_ready  output  1  controller can accept a request this cycle.
- clk_out  output  1  divided clock, driven directly from a flop.
- period_tick  output  1  one-cycle pulse on the last clk_in cycle of each clk_out period.
- busy  output  1  high in RUN and PEND.
- cfg_err  output  1  one-cycle pulse, the cycle after an illegal ratio (1) is accepted.

Behaviour:
- Reset (reset=0, async): state=OFF, cnt=0, cur_div=0, pend_div=0, clk_out=0, period_tick=0, busy=0, cfg_err=0, cfg_ready=1. Deassertion is synchronised externally.
- Handshake: a request is accepted on any rising edge where cfg_valid=1 and cfg_ready=1. cfg_ready is 1 in OFF and RUN and 0 in PEND. cfg_div must be held stable while cfg_valid=1 and cfg_ready=0.
- Illegal ratio (cfg_div=1): accepted, cfg_err pulses the next cycle, no other state change in any state.
- Period shape for ratio N: cnt runs 0..N-1. clk_out=1 iff cnt < N>>1, so high for floor(N/2) cycles and low for the rest. period_tick=1 iff cnt==N-1. cnt and clk_out update on the same edge.
- State OFF: clk_out=0, cnt=0.
  - Accepting N≥2: cur_div=N, cnt=0, go to RUN. clk_out=1 in the first cycle after acceptance, so latency from accept edge to clk_out rise is 1 cycle.
  - Accepting N=0: stay in OFF, no other effect.
- State RUN: cnt increments and wraps from N-1 to 0.
  - Accepting N≠1: pend_div=N, go to PEND. The current period continues unchanged.
- State PEND: counting continues with cur_div. On the edge ending a period (cnt==cur_div-1):
  - pend_div=0: go to OFF, clk_out=0, cnt=0.
  - otherwise: cur_div=pend_div, cnt=0, go to RUN. The new period starts immediately with no extra cycle.
- Request on the boundary cycle: a request accepted in RUN on the same edge as cnt==N-1 is stored in pend_div. It applies at the end of the following period, never mid-edge.
- Same ratio re-requested: the PEND→RUN pass is still taken, and the output is identical to uninterrupted running.
- Reset mid-period: clk_out drops to 0 asynchronously and any pending ratio is discarded.
- No combinational path from cfg_* inputs to clk_out.

Test Plan:
- Reset, then request N=4 at edge t → clk_out sequence 1,1,0,0 repeating from cycle t+1; period_tick high at cycles t+4, t+8; busy=1.
- Running N=4, request N=6 while cnt=1 → cfg_ready=0 until the boundary; remaining 2 cycles keep the N=4 shape; next period 1,1,1,0,0,0; no high phase shorter than 2 cycles.
- Running N=5, request N=0 → current period finishes as 1,1,0,0,0; then OFF: clk_out=0, busy=0, cfg_ready=1.
- Request N=1 in OFF and in RUN(N=3) → cfg_err pulses exactly one cycle each time; N=3 waveform (1,0,0) continues undisturbed; state unchanged.
- Running N=2 with a request accepted on the period_tick cycle → next period still N=2; new ratio starts one full period later.
- Pull reset low mid-period with PEND pending N=7 → clk_out=0 immediately, cfg_ready=1; after release, a request for N=3 gives 1,0,0 with no trace of the discarded N=7.
